// File: rtl/xor_parity_sched_if.sv
// rtl/xor_parity_sched_if.sv - requester/engine signal bundle for the shared parity engine
interface xor_parity_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  done;
    logic [IW-1:0]         done_id;
    logic                  parity;

    modport master (
        output req, data,
        input  gnt, busy, done, done_id, parity
    );

    modport slave (
        input  req, data,
        output gnt, busy, done, done_id, parity
    );
endinterface

// File: rtl/xor_parity_sched.sv
// rtl/xor_parity_sched.sv - round-robin time-shared parity engine around one XOR5 cell
module xor5_sc (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic e,
    output logic y
);
    assign y = a ^ b ^ c ^ d ^ e;
endmodule

module xor_parity_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    xor_parity_sched_if.slave  bus
);
    localparam int NF = WIDTH / 4;
    localparam int CW = (NF > 1) ? $clog2(NF) : 1;
    localparam int IW = $clog2(NREQ);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  sr, sr_nxt;
    logic              acc, acc_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [IW-1:0]     owner, owner_nxt;
    logic [IW-1:0]     last, last_nxt;
    logic [NREQ-1:0]   gnt_nxt;
    logic              busy_nxt, done_nxt, parity_nxt;
    logic [IW-1:0]     done_id_nxt;
    logic              fold;
    logic              found;
    logic [IW-1:0]     win;

    xor5_sc u_xor5 (
        .a (acc),
        .b (sr[0]),
        .c (sr[1]),
        .d (sr[2]),
        .e (sr[3]),
        .y (fold)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sr          <= '0;
            acc         <= 1'b0;
            cnt         <= '0;
            owner       <= '0;
            last        <= IW'(NREQ - 1);
            bus.gnt     <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.done_id <= '0;
            bus.parity  <= 1'b0;
        end else begin
            state       <= state_nxt;
            sr          <= sr_nxt;
            acc         <= acc_nxt;
            cnt         <= cnt_nxt;
            owner       <= owner_nxt;
            last        <= last_nxt;
            bus.gnt     <= gnt_nxt;
            bus.busy    <= busy_nxt;
            bus.done    <= done_nxt;
            bus.done_id <= done_id_nxt;
            bus.parity  <= parity_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sr_nxt      = sr;
        acc_nxt     = acc;
        cnt_nxt     = cnt;
        owner_nxt   = owner;
        last_nxt    = last;
        gnt_nxt     = '0;
        busy_nxt    = bus.busy;
        done_nxt    = 1'b0;
        done_id_nxt = bus.done_id;
        parity_nxt  = bus.parity;
        found       = 1'b0;
        win         = '0;

        // Scan starts just after the previous winner so every requester gets a turn.
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && bus.req[(int'(last) + i) % NREQ]) begin
                found = 1'b1;
                win   = IW'((int'(last) + i) % NREQ);
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    sr_nxt    = bus.data[int'(win)*WIDTH +: WIDTH];
                    acc_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    owner_nxt = win;
                    last_nxt  = win;
                    gnt_nxt   = NREQ'(1) << win;
                    busy_nxt  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                acc_nxt = fold;
                sr_nxt  = sr >> 4;
                cnt_nxt = cnt + CW'(1);
                if (cnt == CW'(NF - 1)) begin
                    parity_nxt  = fold;
                    done_id_nxt = owner;
                    done_nxt    = 1'b1;
                    busy_nxt    = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_xor_parity_sched.sv
// tb/tb_xor_parity_sched.sv - self-checking bench for xor_parity_sched (NREQ=4, WIDTH=16)
module tb_xor_parity_sched;
    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst = 1'b0;

    int   checks = 0;
    int   errors = 0;
    int   last_ref = 3;
    logic prev_par = 1'b0;

    xor_parity_sched_if #(.NREQ(4), .WIDTH(16)) bus ();

    xor_parity_sched #(.NREQ(4), .WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = clk_en ? ~clk : clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_winner(input logic [3:0] r);
        for (int i = 1; i <= 4; i++) begin
            if (r[(last_ref + i) % 4]) return (last_ref + i) % 4;
        end
        return 0;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},     64'(bus.gnt),     64'd0);
        check({tag, "_busy"},    64'(bus.busy),    64'd0);
        check({tag, "_done"},    64'(bus.done),    64'd0);
        check({tag, "_done_id"}, 64'(bus.done_id), 64'd0);
        check({tag, "_parity"},  64'(bus.parity),  64'd0);
    endtask

    // Presents a word while the engine is idle, then follows it to completion.
    task automatic transact(input logic [3:0] r, input logic [63:0] d, input bit keep);
        int   w;
        logic p;
        logic [15:0] word;
        w    = model_winner(r);
        word = d[w*16 +: 16];
        p    = ^word;
        bus.req  = r;
        bus.data = d;
        @(negedge clk);
        check("gnt_onehot", 64'(bus.gnt), 64'd1 << w);
        check("busy_after_gnt", 64'(bus.busy), 64'd1);
        check("done_at_gnt", 64'(bus.done), 64'd0);
        last_ref = w;
        if (!keep) begin
            bus.req  = '0;
            bus.data = ~d;
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k < 4) begin
                check("done_early", 64'(bus.done), 64'd0);
                check("gnt_in_run", 64'(bus.gnt), 64'd0);
                check("busy_in_run", 64'(bus.busy), 64'd1);
                check("parity_hold", 64'(bus.parity), 64'(prev_par));
            end else begin
                check("done_pulse", 64'(bus.done), 64'd1);
                check("gnt_at_done", 64'(bus.gnt), 64'd0);
                check("done_id", 64'(bus.done_id), 64'(w));
                check("parity", 64'(bus.parity), 64'(p));
                check("busy_at_done", 64'(bus.busy), 64'd0);
                prev_par = p;
            end
        end
    endtask

    initial begin
        int w;
        logic [63:0] d;
        bus.req  = '0;
        bus.data = '0;

        // Asynchronous reset with the clock stopped
        #3 rst = 1'b1;
        #1 check_all_zero("async_rst");
        clk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("post_rst");

        // All requesters held: rotation from the reset pointer, 5 cycles per word
        d = 64'h8421_0F0F_1234_ABCD;
        for (int n = 0; n < 5; n++) transact(4'b1111, d, 1'b1);

        // Single-word directed cases on requester 0
        transact(4'b0001, 64'h0000_0000_0000_0001, 1'b0);
        transact(4'b0001, 64'h0000_0000_0000_FFFF, 1'b0);
        transact(4'b0001, 64'h0000_0000_0000_8000, 1'b0);
        transact(4'b0001, 64'h0000_0000_0000_0007, 1'b0);

        // Requester 1 drops req and changes data right after its grant
        transact(4'b0010, 64'h0000_0000_0001_0000, 1'b0);

        // Reset in the middle of an operation
        d = {$urandom, $urandom};
        w = model_winner(4'b0100);
        bus.req  = 4'b0100;
        bus.data = d;
        @(negedge clk);
        check("rst_case_gnt", 64'(bus.gnt), 64'd1 << w);
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 check_all_zero("mid_run_rst");
        last_ref = 3;
        prev_par = 1'b0;
        #1 rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("no_done_after_rst", 64'(bus.done), 64'd0);
        end
        check("idle_after_rst", 64'(bus.busy), 64'd0);
        transact(4'b1010, {$urandom, $urandom}, 1'b0);

        // Random requests and words against the reference model
        for (int n = 0; n < 16; n++) begin
            transact(4'($urandom_range(1, 15)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
